// File: rtl/fp_mult_pipe.sv
// Three-stage floating-point multiplier: unpack/classify, mantissa product, normalise/round/pack.
// Subnormals flush to zero; all stages advance together under valid/ready backpressure.
module fp_mult_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [EXP_W+MAN_W:0]     a,
  input  logic [EXP_W+MAN_W:0]     b,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [EXP_W+MAN_W:0]     result,
  output logic [3:0]               flags
);

  localparam int SW     = EXP_W + 2;
  localparam int PW     = 2 * MAN_W + 2;
  localparam int BIAS_I = (1 << (EXP_W - 1)) - 1;
  localparam logic [SW-1:0] EMAX = SW'((1 << EXP_W) - 1);

  typedef enum logic [1:0] {K_NORM, K_ZERO, K_INF, K_NAN} kind_t;

  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // Stage 1: classify operands and form the biased exponent sum
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] fa, fb;
  logic             a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic             u_inv;
  kind_t            u_kind;
  logic [SW-1:0]    u_exp;

  assign ea = a[EXP_W+MAN_W-1:MAN_W];
  assign eb = b[EXP_W+MAN_W-1:MAN_W];
  assign fa = a[MAN_W-1:0];
  assign fb = b[MAN_W-1:0];

  always_comb begin
    a_zero = (ea == '0);
    b_zero = (eb == '0);
    a_inf  = (ea == '1) && (fa == '0);
    b_inf  = (eb == '1) && (fb == '0);
    a_nan  = (ea == '1) && (fa != '0);
    b_nan  = (eb == '1) && (fb != '0);
    u_inv  = (a_inf && b_zero) || (b_inf && a_zero);
    u_exp  = {2'b00, ea} + {2'b00, eb} - SW'(BIAS_I);
    if (a_nan || b_nan || u_inv)  u_kind = K_NAN;
    else if (a_inf || b_inf)      u_kind = K_INF;
    else if (a_zero || b_zero)    u_kind = K_ZERO;
    else                          u_kind = K_NORM;
  end

  logic             s1_valid, s1_sign, s1_inv;
  kind_t            s1_kind;
  logic [SW-1:0]    s1_exp;
  logic [MAN_W:0]   s1_ma, s1_mb;

  logic             s2_valid, s2_sign, s2_inv;
  kind_t            s2_kind;
  logic [SW-1:0]    s2_exp;
  logic [PW-1:0]    s2_prod;

  // Stage 3: normalise by at most one place, round to nearest even, pack
  logic              norm, guard, sticky, round_up, carry;
  logic [MAN_W:0]    mant_n;
  logic [MAN_W+1:0]  mant_r;
  logic [MAN_W-1:0]  man_f;
  logic [SW-1:0]     exp_f;
  logic [EXP_W+MAN_W:0] r_next;
  logic [3:0]        f_next;

  always_comb begin
    norm     = s2_prod[PW-1];
    mant_n   = norm ? s2_prod[PW-1:MAN_W+1] : s2_prod[PW-2:MAN_W];
    guard    = norm ? s2_prod[MAN_W]        : s2_prod[MAN_W-1];
    sticky   = norm ? |s2_prod[MAN_W-1:0]   : |s2_prod[MAN_W-2:0];
    round_up = guard && (sticky || mant_n[0]);
    mant_r   = {1'b0, mant_n} + (MAN_W+2)'(round_up);
    carry    = mant_r[MAN_W+1];
    man_f    = carry ? '0 : mant_r[MAN_W-1:0];
    exp_f    = s2_exp + SW'(norm) + SW'(carry);
    r_next   = '0;
    f_next   = '0;
    case (s2_kind)
      K_NAN: begin
        r_next = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
        f_next = {s2_inv, 3'b000};
      end
      K_INF:  r_next = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      K_ZERO: r_next = {s2_sign, {(EXP_W+MAN_W){1'b0}}};
      default: begin
        if ($signed(exp_f) >= $signed(EMAX)) begin
          r_next = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
          f_next = 4'b0101;
        end else if (exp_f[SW-1] || exp_f == '0) begin
          r_next = {s2_sign, {(EXP_W+MAN_W){1'b0}}};
          f_next = 4'b0011;
        end else begin
          r_next = {s2_sign, exp_f[EXP_W-1:0], man_f};
          f_next = {3'b000, guard || sticky};
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_sign   <= 1'b0;
      s1_inv    <= 1'b0;
      s1_kind   <= K_NORM;
      s1_exp    <= '0;
      s1_ma     <= '0;
      s1_mb     <= '0;
      s2_valid  <= 1'b0;
      s2_sign   <= 1'b0;
      s2_inv    <= 1'b0;
      s2_kind   <= K_NORM;
      s2_exp    <= '0;
      s2_prod   <= '0;
      out_valid <= 1'b0;
      result    <= '0;
      flags     <= '0;
    end else if (adv) begin
      s1_valid  <= in_valid;
      s1_sign   <= a[EXP_W+MAN_W] ^ b[EXP_W+MAN_W];
      s1_inv    <= u_inv;
      s1_kind   <= u_kind;
      s1_exp    <= u_exp;
      s1_ma     <= {1'b1, fa};
      s1_mb     <= {1'b1, fb};
      s2_valid  <= s1_valid;
      s2_sign   <= s1_sign;
      s2_inv    <= s1_inv;
      s2_kind   <= s1_kind;
      s2_exp    <= s1_exp;
      s2_prod   <= PW'(s1_ma) * PW'(s1_mb);
      out_valid <= s2_valid;
      if (s2_valid) begin
        result <= r_next;
        flags  <= f_next;
      end
    end
  end

endmodule

// File: tb/tb_fp_mult_pipe.sv
// Scoreboard bench for fp_mult_pipe (binary32): directed vectors, backpressure,
// mid-flight reset and a random stream checked against an integer reference model.
module tb_fp_mult_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0, b = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic [3:0]  flags;

  fp_mult_pipe #(.EXP_W(8), .MAN_W(23)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .flags(flags)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic [3:0]  fl;
    int          cyc;
    bit          lat;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [31:0] e_res = '0;
  logic [3:0]  e_fl = '0;
  bit          e_lat = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pushes on input transfers, pops/compares on output transfers, checks hold
  bit          prev_stall = 1'b0;
  logic [31:0] prev_res;
  logic [3:0]  prev_fl;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        checks++;
        if (!out_valid || result !== prev_res || flags !== prev_fl) begin
          errors++;
          $display("FAIL hold: got v=%b %h/%b required v=1 %h/%b", out_valid, result, flags, prev_res, prev_fl);
        end
      end
      if (out_valid && out_ready) begin
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output: got %h/%b required no output", result, flags);
        end else begin
          e = sb.pop_front();
          if (result !== e.res || flags !== e.fl) begin
            errors++;
            $display("FAIL product: got %h/%b required %h/%b", result, flags, e.res, e.fl);
          end
          if (e.lat) begin
            checks++;
            if (cyc - e.cyc != 3) begin
              errors++;
              $display("FAIL latency: got %0d required 3", cyc - e.cyc);
            end
          end
        end
      end
      if (in_valid && in_ready) sb.push_back('{e_res, e_fl, cyc, e_lat});
      prev_stall = out_valid && !out_ready;
      prev_res   = result;
      prev_fl    = flags;
    end
  end

  function automatic void ref_mul(input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] r, output logic [3:0] f);
    int          ex, ey, e, sh;
    logic [22:0] mx, my;
    bit          s, xn, yn, xi, yi, xz, yz;
    longint unsigned p, q, rem, half;
    ex = int'(x[30:23]); ey = int'(y[30:23]);
    mx = x[22:0];        my = y[22:0];
    s  = x[31] ^ y[31];
    xn = (ex == 255) && (mx != 0); yn = (ey == 255) && (my != 0);
    xi = (ex == 255) && (mx == 0); yi = (ey == 255) && (my == 0);
    xz = (ex == 0);                yz = (ey == 0);
    f  = 4'b0000;
    if (xn || yn || (xi && yz) || (yi && xz)) begin
      r = 32'h7FC00000;
      if ((xi && yz) || (yi && xz)) f = 4'b1000;
    end else if (xi || yi) begin
      r = {s, 8'hFF, 23'd0};
    end else if (xz || yz) begin
      r = {s, 31'd0};
    end else begin
      p  = longint'({1'b1, mx}) * longint'({1'b1, my});
      e  = ex + ey - 127;
      sh = 23;
      if (p >= (64'd1 << 47)) begin sh = 24; e++; end
      q    = p >> sh;
      rem  = p - (q << sh);
      half = 64'd1 << (sh - 1);
      if (rem > half || (rem == half && (q % 2) == 1)) q++;
      if (q == (64'd1 << 24)) begin q = q >> 1; e++; end
      if (e >= 255) begin
        r = {s, 8'hFF, 23'd0};
        f = 4'b0101;
      end else if (e <= 0) begin
        r = {s, 31'd0};
        f = 4'b0011;
      end else begin
        r = {s, 8'(e), 23'(q)};
        f = {3'b000, rem != 0};
      end
    end
  endfunction

  function automatic logic [31:0] gen_op();
    logic [7:0]  ex;
    logic [22:0] m;
    case ($urandom_range(0, 9))
      0:       ex = 8'd0;
      1:       ex = 8'd255;
      2:       ex = 8'd1;
      3:       ex = 8'd254;
      4, 5:    ex = 8'($urandom_range(40, 80));
      6, 7:    ex = 8'($urandom_range(170, 215));
      default: ex = 8'($urandom_range(100, 154));
    endcase
    m = ($urandom_range(0, 3) == 0) ? 23'd0 : 23'($urandom);
    return {1'($urandom), ex, m};
  endfunction

  task automatic set_op(input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] r, input logic [3:0] f, input bit lat);
    a = x; b = y; e_res = r; e_fl = f; e_lat = lat; in_valid = 1'b1;
  endtask

  // Holds the operand until accepted; bounded so a stuck in_ready cannot hang the run
  task automatic wait_accept();
    bit acc = 1'b0;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
    end
    if (!acc) begin
      checks++; errors++;
      $display("FAIL accept_timeout: got in_ready=0 required 1");
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && sb.size() != 0; i++) @(posedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d outstanding required 0", sb.size());
    end
  endtask

  logic [31:0] da[7] = '{32'h40000000, 32'h3F800001, 32'h3FC00000, 32'h7F000000,
                         32'h7F800000, 32'h00800000, 32'h80000000};
  logic [31:0] db[7] = '{32'h40400000, 32'h3FC00000, 32'h3FC00000, 32'h7F000000,
                         32'h00000000, 32'h3F000000, 32'h3F800000};
  logic [31:0] dr[7] = '{32'h40C00000, 32'h3FC00002, 32'h40100000, 32'h7F800000,
                         32'h7FC00000, 32'h00000000, 32'h80000000};
  logic [3:0]  df[7] = '{4'b0000, 4'b0001, 4'b0000, 4'b0101, 4'b1000, 4'b0011, 4'b0000};

  logic [31:0] ba[8] = '{32'h3F800000, 32'h40000000, 32'h3FC00000, 32'h3F800001,
                         32'hC0000000, 32'h40800000, 32'h3F800000, 32'h40400000};
  logic [31:0] bb[8] = '{32'h3F800000, 32'h40400000, 32'h3FC00000, 32'h3FC00000,
                         32'h3F000000, 32'h40800000, 32'hBF800000, 32'h40400000};
  logic [31:0] br[8] = '{32'h3F800000, 32'h40C00000, 32'h40100000, 32'h3FC00002,
                         32'hBF800000, 32'h41800000, 32'hBF800000, 32'h41100000};
  logic [3:0]  bf[8] = '{4'b0000, 4'b0000, 4'b0000, 4'b0001,
                         4'b0000, 4'b0000, 4'b0000, 4'b0000};

  initial begin
    logic [31:0] x, y, r;
    logic [3:0]  f;
    int          idx, sent, k;
    bit          pend;

    #1 rst_n = 1'b0;
    #2;
    checks++;
    if (out_valid !== 1'b0 || result !== '0 || flags !== '0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: got v=%b r=%h f=%b rdy=%b required v=0 r=0 f=0 rdy=1",
               out_valid, result, flags, in_ready);
    end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed vectors, one at a time, with latency check
    for (int i = 0; i < 7; i++) begin
      set_op(da[i], db[i], dr[i], df[i], 1'b1);
      wait_accept();
      in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
    end
    drain();

    // Backpressure: continuous stream, out_ready low in stream cycles 4..6
    @(posedge clk); #1;
    idx = 0;
    for (k = 0; k < 40 && idx < 8; k++) begin
      out_ready = !(k >= 4 && k <= 6);
      set_op(ba[idx], bb[idx], br[idx], bf[idx], 1'b0);
      @(negedge clk);
      if (k >= 4 && k <= 6) begin
        checks++;
        if (in_ready !== 1'b0) begin
          errors++;
          $display("FAIL bp_in_ready: cycle %0d got %b required 0", k, in_ready);
        end
      end
      if (in_ready) idx++;
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain();

    // Reset with three products in flight
    for (int i = 0; i < 3; i++) begin
      set_op(ba[i], bb[i], br[i], bf[i], 1'b0);
      wait_accept();
    end
    in_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_flush: got out_valid=%b required 0", out_valid);
    end
    sb.delete();
    #8 rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL post_reset_idle: got out_valid=%b required 0", out_valid);
      end
    end
    @(posedge clk); #1;
    set_op(da[0], db[0], dr[0], df[0], 1'b1);
    wait_accept();
    in_valid = 1'b0;
    drain();

    // Random stream against the reference model under random out_ready
    sent = 0;
    pend = 1'b0;
    for (int c = 0; c < 60000 && sent < 10000; c++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if (!pend && $urandom_range(0, 4) != 0) begin
        x = gen_op();
        y = gen_op();
        ref_mul(x, y, r, f);
        set_op(x, y, r, f, 1'b0);
        pend = 1'b1;
      end
      @(negedge clk);
      if (pend && in_ready) begin
        pend = 1'b0;
        sent++;
      end
      @(posedge clk); #1;
      if (!pend) in_valid = 1'b0;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    checks++;
    if (sent != 10000) begin
      errors++;
      $display("FAIL random_issue: got %0d sent required 10000", sent);
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
